// File: rtl/rr_mux8_if.sv
// Request/data/grant bundle between the requester side and rr_mux8_scheduler.
interface rr_mux8_if;
    logic [7:0] req;
    logic [7:0] w;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       valid;
    logic       y;
    logic       busy;

    modport master (
        output req,
        output w,
        input  sel,
        input  grant,
        input  valid,
        input  y,
        input  busy
    );

    modport slave (
        input  req,
        input  w,
        output sel,
        output grant,
        output valid,
        output y,
        output busy
    );
endinterface

// File: rtl/rr_mux8_scheduler.sv
// Round-robin scheduler granting one of 8 requesters at a time, each for at most
// HOLD_CYCLES cycles, and steering the granted source's data bit onto y.
module rr_mux8_scheduler #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic         clk,
    input logic         rst,
    rr_mux8_if.slave    bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             release_grant;
    logic [2:0]       next_start;

    // First set bit of r, searching upward from start with mod-8 wrap.
    function automatic logic [2:0] arb(input logic [2:0] start, input logic [7:0] r);
        logic [2:0] idx;
        logic [2:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign next_start    = sel_q + 3'd1;
    assign release_grant = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                grant_d = 8'h00;
                valid_d = 1'b0;
                if (bus.req != 8'h00) begin
                    sel_d   = arb(ptr_q, bus.req);
                    grant_d = 8'h01 << sel_d;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!release_grant) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    ptr_d = next_start;
                    // Back-to-back handover: the releasing source is searched last.
                    if (bus.req != 8'h00) begin
                        sel_d   = arb(next_start, bus.req);
                        grant_d = 8'h01 << sel_d;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        grant_d = 8'h00;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = valid_d && ((bus.req & ~grant_d) != 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            grant_q <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.y     = valid_q ? bus.w[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux8_scheduler.sv
// Directed bench for rr_mux8_scheduler with HOLD_CYCLES=4 and hand-computed expectations.
module tb_rr_mux8_scheduler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic w2;
    logic [7:0] wv;

    rr_mux8_if bus ();

    rr_mux8_scheduler #(
        .HOLD_CYCLES(4),
        .CNT_W      (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_sel, input logic [7:0] e_grant,
                             input logic e_valid, input logic e_busy);
        check({tag, "_sel"}, {5'd0, bus.sel}, {5'd0, e_sel});
        check({tag, "_grant"}, bus.grant, e_grant);
        check({tag, "_valid"}, {7'd0, bus.valid}, {7'd0, e_valid});
        check({tag, "_busy"}, {7'd0, bus.busy}, {7'd0, e_busy});
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.req = 8'hFF;
        bus.w   = 8'h00;

        // Reset held for two edges with every source requesting.
        tick();
        tick();
        check_out("reset", 3'd0, 8'h00, 1'b0, 1'b0);
        check("reset_y", {7'd0, bus.y}, 8'h00);

        // Full contention: 0..7,0 each for exactly 4 cycles.
        rst = 1'b0;
        tick();
        check_out("first_grant", 3'd0, 8'h01, 1'b1, 1'b1);
        for (int i = 1; i < 36; i++) begin
            tick();
            check_out("contention", 3'((i / 4) % 8), 8'h01 << ((i / 4) % 8), 1'b1, 1'b1);
        end

        // Single requester on source 5: continuous re-grant, never busy.
        rst     = 1'b1;
        bus.req = 8'h20;
        tick();
        rst = 1'b0;
        tick();
        check_out("single_first", 3'd5, 8'h20, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("single_hold", 3'd5, 8'h20, 1'b1, 1'b0);
        end

        // Early drop of source 3 hands over to source 6 with a fresh hold count.
        rst     = 1'b1;
        bus.req = 8'h48;
        tick();
        rst = 1'b0;
        tick();
        check_out("drop_g3", 3'd3, 8'h08, 1'b1, 1'b1);
        tick();
        check_out("drop_g3b", 3'd3, 8'h08, 1'b1, 1'b1);
        bus.req = 8'h40;
        tick();
        check_out("drop_g6", 3'd6, 8'h40, 1'b1, 1'b0);
        bus.req = 8'h41;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("drop_g6_hold", 3'd6, 8'h40, 1'b1, 1'b1);
        end
        tick();
        check_out("drop_to0", 3'd0, 8'h01, 1'b1, 1'b1);
        bus.req = 8'h40;
        tick();
        check_out("drop_back6", 3'd6, 8'h40, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        check_out("drop_idle", 3'd6, 8'h00, 1'b0, 1'b0);
        check("drop_idle_y", {7'd0, bus.y}, 8'h00);

        // Datapath: y follows w[2] combinationally while source 2 holds the grant.
        rst     = 1'b1;
        bus.req = 8'h04;
        tick();
        rst = 1'b0;
        tick();
        check_out("dp_grant", 3'd2, 8'h04, 1'b1, 1'b0);
        w2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w2     = ~w2;
            wv     = 8'($urandom);
            wv[2]  = w2;
            bus.w  = wv;
            #1;
            check("dp_y", {7'd0, bus.y}, {7'd0, w2});
            if (i % 2 == 1) tick();
        end
        bus.req = 8'h00;
        tick();
        check_out("dp_idle", 3'd2, 8'h00, 1'b0, 1'b0);
        bus.w = 8'hFF;
        #1;
        check("dp_idle_y", {7'd0, bus.y}, 8'h00);

        // Reset in the middle of a grant on source 6.
        bus.w   = 8'h00;
        bus.req = 8'h40;
        tick();
        check_out("mid_g6", 3'd6, 8'h40, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check_out("mid_rst", 3'd0, 8'h00, 1'b0, 1'b0);
        check("mid_rst_y", {7'd0, bus.y}, 8'h00);
        rst     = 1'b0;
        bus.req = 8'h81;
        tick();
        check_out("post_rst_g0", 3'd0, 8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("post_rst_hold", 3'd0, 8'h01, 1'b1, 1'b1);
        end
        tick();
        check_out("post_rst_g7", 3'd7, 8'h80, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux8_scheduler.md
Name: rr_mux8_scheduler

Overview:
Round-robin scheduler that shares one 1-bit output channel among 8 requesters.
- Arbitrates `req[7:0]` and drives the select of an internal 8:1 mux on `w[7:0]`.
- Bounds each grant to HOLD_CYCLES cycles.
- Sits in front of the mux8to1 datapath and replaces a free-running select counter with request-driven sequencing.

Parameters:
HOLD_CYCLES, 4, max consecutive cycles one requester keeps the grant; legal 1..255
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  8  request per source, level-sensitive, bit i = source i
w    input  8  data bit per source (mux data inputs)
sel  output 3  registered mux select = index of granted source
grant output 8  registered one-hot grant, 0 when idle
valid output 1  registered, 1 while a grant is active
y    output 1  combinational: w[sel] when valid=1, else 0
busy output 1  registered, 1 when any req bit is pending while a grant is active on another source

Behaviour:
- Reset (rst=1 at edge):
  - sel=0, grant=0, valid=0, busy=0.
  - Internal pointer ptr=0, hold counter cnt=0, state=IDLE.
  - Therefore y=0.
  - Reset has priority over every other event, including mid-grant; the grant is dropped at that edge.
- Arbitration function ARB(ptr, r) returns the first set bit of r, searching ptr, ptr+1, ... 7, 0, ... ptr-1 (mod-8 wrap).
- State IDLE:
  - If req != 0 at an edge: sel <= ARB(ptr, req), grant <= one-hot(sel), valid <= 1, cnt <= 0, state <= GRANT.
  - Else hold all outputs at 0/idle.
  - Latency req -> grant is 1 clock edge.
- State GRANT: release condition at an edge is req[sel]==0 OR cnt==HOLD_CYCLES-1.
  - No release: cnt <= cnt+1; sel, grant and valid hold.
  - Release:
    - ptr <= (sel+1) mod 8; 7 wraps to 0.
    - If req != 0: re-arbitrate the same edge with ARB((sel+1) mod 8, req), load the new grant, cnt <= 0, stay in GRANT. This is a back-to-back handover with no idle bubble; valid stays 1.
    - Else: grant <= 0, valid <= 0, sel holds its last value, state <= IDLE.
- Re-grant: the current source competes last, so it is re-granted only if no other bit of req is set.
- Deasserting req: a requester that drops req keeps grant for the remainder of that cycle; grant drops at the next edge.
- HOLD_CYCLES=1: every grant lasts exactly 1 cycle; with all requesting, sel advances every cycle.
- busy <= valid_next AND (req AND ~grant_next) != 0, registered.
- y is purely combinational from sel, valid and w. It has no register, so w changes propagate the same cycle.
- No X on outputs after the first reset edge. Requests on non-granted sources never affect sel or y.

Test Plan:
1. Reset: rst=1 for 2 edges with req=8'hFF.
   - During reset: grant=0, valid=0, sel=0, y=0.
   - First edge after rst=0: grant=8'h01, sel=0, valid=1.
2. Single requester: req=8'h20 held, HOLD_CYCLES=4.
   - Response: sel=5, grant=8'h20.
   - After 4 cycles it is re-granted with no gap; valid stays 1 continuously and busy=0.
3. Full contention: req=8'hFF, HOLD_CYCLES=4.
   - sel sequence is 0,1,2,...,7,0, each held exactly 4 cycles.
   - valid stays 1 and busy=1 throughout.
4. Early drop: grant on source 3 with req=8'h48; drop req[3] after 2 granted cycles.
   - Next edge: sel=6, grant=8'h40, cnt restarts, ptr=4.
   - When req then goes to 0: valid=0 one edge after req[6] falls.
5. Datapath: grant sel=2; toggle w[2] every cycle and w[7:3] randomly.
   - y equals w[2] same-cycle.
   - With req=0 and valid=0, y=0 regardless of w=8'hFF.
6. Reset mid-grant: assert rst while sel=6 and valid=1.
   - Next edge: all outputs 0.
   - Then req=8'h81 gives sel=0 first (ptr reset), then sel=7.
